// File: rtl/msg_assembler_pkg.sv
// Shared constants and FSM encoding for the message assembler.
// Imported by the top module and by its charset RAM.
package msg_assembler_pkg;
    localparam int MSG_BYTES     = 64;
    localparam int CHARSET_DEPTH = 128;
    localparam int TAG_W         = 49;
    localparam int OFF_W         = 6;
    localparam int IDX_W         = 7;
    localparam int BLOCK_W       = MSG_BYTES * 8;

    localparam logic [1:0] OVR_UPDATE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/msg_assembler_charset_ram.sv
// Charset lookup table: 128 x 8, one write port, registered read.
// Contents survive reset; only config writes change them.
module msg_assembler_charset_ram
    import msg_assembler_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem [CHARSET_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/msg_assembler.sv
// Applies char_gen (offset, char) updates to a 64-byte template and presents
// one tagged 512-bit candidate per cycle; also sequences char_gen run control.
module msg_assembler
    import msg_assembler_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [7:0]         cfg_data,
    input  logic               start,
    output logic               gen_reset,
    input  logic [TAG_W-1:0]   gen_counter,
    input  logic [OFF_W-1:0]   gen_offset,
    input  logic [IDX_W-1:0]   gen_char,
    input  logic [1:0]         gen_override,
    input  logic               gen_finished,
    output logic [BLOCK_W-1:0] msg_block,
    output logic [TAG_W-1:0]   msg_tag,
    output logic               msg_valid,
    input  logic               out_ready,
    output logic               err_drop,
    output logic               busy,
    output logic               done,
    output state_t             dbg_state
);
    state_t             state, state_next;
    logic               drain_cnt, drain_cnt_next;
    logic               err_next;
    logic               cfg_ok, start_ok;
    logic               s1_live, s1_we;
    logic [OFF_W-1:0]   s1_offset;
    logic [TAG_W-1:0]   s1_tag;
    logic [7:0]         cs_data;
    logic [BLOCK_W-1:0] template, tmpl_next;

    assign cfg_ok   = cfg_we && (state == ST_IDLE);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            err_drop  <= err_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        err_next       = err_drop;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (gen_finished) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Two cycles flush the S1 and S2 stages.
                drain_cnt_next = drain_cnt + 1'b1;
                if (drain_cnt) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (msg_valid && !out_ready) err_next = 1'b1;
        if (start_ok) err_next = 1'b0;
    end

    assign gen_reset = (state != ST_RUN);
    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    msg_assembler_charset_ram u_charset_ram (
        .clk   (clk),
        .we    (cfg_ok && cfg_sel),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (gen_char),
        .rdata (cs_data)
    );

    // S1: capture offset/tag alongside the registered charset read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_live   <= 1'b0;
            s1_we     <= 1'b0;
            s1_offset <= '0;
            s1_tag    <= '0;
        end else begin
            s1_live   <= (state == ST_RUN);
            s1_offset <= gen_offset;
            s1_tag    <= gen_counter;
            if ((state == ST_RUN) && (gen_override == OVR_UPDATE)) s1_we <= 1'b1;
            else s1_we <= 1'b0;
        end
    end

    always_comb begin
        tmpl_next = template;
        if (s1_we) begin
            tmpl_next[{s1_offset, 3'b000} +: 8] = cs_data;
        end else if (cfg_ok && !cfg_sel) begin
            tmpl_next[{cfg_addr[OFF_W-1:0], 3'b000} +: 8] = cfg_data;
        end
    end

    // The template register is the presented block, so an S2 write shows the same edge.
    always_ff @(posedge clk) begin
        template <= tmpl_next;
    end

    assign msg_block = template;

    // msg_valid is a one-shot beat with no stall: when out_ready is low that
    // cycle the beat is lost and err_drop latches until the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_tag   <= '0;
            msg_valid <= 1'b0;
        end else begin
            msg_tag   <= s1_tag;
            msg_valid <= s1_live && !s1_tag[TAG_W-1];
        end
    end
endmodule
